// File: rtl/kl_pkg.sv
// +----------------------------------------------------------------------------+
// | kl_pkg : KL bus field widths, responder FSM encoding and size helpers      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package kl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int SIZE_W = 3;
  localparam int ID_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BURST = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RD_BURST = 3'd3,
    ST_WR_ACK   = 3'd4
  } kl_state_e;

  // Index of the final beat of a burst; size codes above 3 behave as 3.
  function automatic logic [2:0] last_beat(input logic [SIZE_W-1:0] size);
    logic [1:0] eff;
    eff = size[2] ? 2'd3 : size[1:0];
    return {eff == 2'd3, eff >= 2'd2, eff >= 2'd1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/kl_ram_array.sv
// +----------------------------------------------------------------------------+
// | kl_ram_array : 2^DEPTH_LOG2 x 64 RAM, byte-masked sync write, async read   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module kl_ram_array
  import kl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [MASK_W-1:0]     wmask,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask[i]) r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/kl_ram_responder.sv
// +----------------------------------------------------------------------------+
// | kl_ram_responder : KL bus RAM responder with programmable response latency |
// | Optional LFSR backpressure when KL_RAM_STALL_EN is defined.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module kl_ram_responder
  import kl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_req_addr,
  input  logic              bus_req_wen,
  input  logic [DATA_W-1:0] bus_req_wdata,
  input  logic [MASK_W-1:0] bus_req_wmask,
  input  logic [SIZE_W-1:0] bus_req_size,
  input  logic [ID_W-1:0]   bus_req_srcid,
  input  logic              bus_req_valid,
  output logic              bus_req_ready,
  output logic [DATA_W-1:0] bus_resp_rdata,
  output logic              bus_resp_ren,
  output logic [SIZE_W-1:0] bus_resp_size,
  output logic [ID_W-1:0]   bus_resp_dstid,
  output logic              bus_resp_valid,
  input  logic              bus_resp_ready
);

  localparam logic [3:0]            c_lat_init = 4'(LATENCY - 1);
  localparam logic [DEPTH_LOG2-1:0] c_one      = DEPTH_LOG2'(1);

  kl_state_e             r_state, w_state_nx;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [SIZE_W-1:0]     r_size;
  logic [ID_W-1:0]       r_srcid;
  logic                  r_wen;
  logic [3:0]            r_lat;
  logic [2:0]            r_beat;
  logic                  r_live;

  logic                  w_req_gate, w_resp_gate;
  logic                  w_req_hs, w_resp_hs, w_beat_last;
  logic [DEPTH_LOG2-1:0] w_req_idx;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_waddr;
  logic [DATA_W-1:0]     w_mem_rdata;
  logic                  w_unused;

  assign w_unused    = &{1'b0, bus_req_addr[ADDR_W-1:DEPTH_LOG2+3], bus_req_addr[2:0]};
  assign w_req_idx   = bus_req_addr[DEPTH_LOG2+2:3];
  assign w_req_hs    = bus_req_valid & bus_req_ready;
  assign w_resp_hs   = bus_resp_valid & bus_resp_ready;
  assign w_beat_last = (r_beat == last_beat(r_size));

`ifdef KL_RAM_STALL_EN
  logic [15:0] r_lfsr;
  logic        r_shown;

  // r_shown keeps a beat asserted once it has been presented and not yet taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr  <= 16'hACE1;
      r_shown <= 1'b0;
    end else begin
      r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_shown <= bus_resp_valid & ~bus_resp_ready;
    end
  end

  assign w_req_gate  = r_lfsr[0];
  assign w_resp_gate = r_lfsr[0] | r_shown;
`else
  assign w_req_gate  = 1'b1;
  assign w_resp_gate = 1'b1;
`endif

  assign w_mem_we    = w_req_hs & (((r_state == ST_IDLE) & bus_req_wen) | (r_state == ST_WR_BURST));
  assign w_mem_waddr = (r_state == ST_IDLE) ? w_req_idx : r_addr;

  kl_ram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (w_mem_waddr),
    .wdata (bus_req_wdata),
    .wmask (bus_req_wmask),
    .raddr (r_addr),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = '0;
    bus_resp_ren   = 1'b0;
    bus_resp_size  = '0;
    bus_resp_dstid = '0;
    case (r_state)
      ST_IDLE: begin
        bus_req_ready = r_live & w_req_gate;
        if (w_req_hs) begin
          if (bus_req_wen && (last_beat(bus_req_size) != 3'd0)) w_state_nx = ST_WR_BURST;
          else                                                  w_state_nx = ST_WAIT;
        end
      end
      ST_WR_BURST: begin
        bus_req_ready = r_live & w_req_gate;
        if (w_req_hs && w_beat_last) w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_lat == 4'd0) w_state_nx = r_wen ? ST_WR_ACK : ST_RD_BURST;
      end
      ST_RD_BURST: begin
        bus_resp_valid = w_resp_gate;
        bus_resp_ren   = 1'b1;
        bus_resp_rdata = w_mem_rdata;
        bus_resp_size  = r_size;
        bus_resp_dstid = r_srcid;
        if (w_resp_hs && w_beat_last) w_state_nx = ST_IDLE;
      end
      ST_WR_ACK: begin
        bus_resp_valid = w_resp_gate;
        bus_resp_size  = r_size;
        bus_resp_dstid = r_srcid;
        if (w_resp_hs) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Writes consume beat 0 on the accepting edge, so the word pointer starts one ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live  <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_srcid <= '0;
      r_wen   <= 1'b0;
      r_lat   <= '0;
      r_beat  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_size  <= bus_req_size;
            r_srcid <= bus_req_srcid;
            r_wen   <= bus_req_wen;
            r_lat   <= c_lat_init;
            if (bus_req_wen) begin
              r_addr <= w_req_idx + c_one;
              r_beat <= 3'd1;
            end else begin
              r_addr <= w_req_idx;
              r_beat <= 3'd0;
            end
          end
        end
        ST_WR_BURST: begin
          if (w_req_hs) begin
            r_addr <= r_addr + c_one;
            r_beat <= r_beat + 3'd1;
            r_lat  <= c_lat_init;
          end
        end
        ST_WAIT: begin
          if (r_lat != 4'd0) r_lat <= r_lat - 4'd1;
        end
        ST_RD_BURST: begin
          if (w_resp_hs) begin
            r_addr <= r_addr + c_one;
            r_beat <= r_beat + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kl_ram_responder.sv
// +----------------------------------------------------------------------------+
// | tb_kl_ram_responder : directed self-checking bench for kl_ram_responder    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_kl_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [2:0]  req_size;
  logic [4:0]  req_srcid;
  logic        req_valid;
  logic        resp_ready;

  logic        a_req_ready, a_ren, a_valid;
  logic [63:0] a_rdata;
  logic [2:0]  a_size;
  logic [4:0]  a_dstid;
  logic        b_req_ready, b_ren, b_valid;
  logic [63:0] b_rdata;
  logic [2:0]  b_size;
  logic [4:0]  b_dstid;

  logic        o_req_ready, o_ren, o_valid;
  logic [63:0] o_rdata;
  logic [2:0]  o_size;
  logic [4:0]  o_dstid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  kl_ram_responder #(.DEPTH_LOG2(16), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .bus_req_addr(req_addr), .bus_req_wen(req_wen), .bus_req_wdata(req_wdata),
    .bus_req_wmask(req_wmask), .bus_req_size(req_size), .bus_req_srcid(req_srcid),
    .bus_req_valid(req_valid & ~sel), .bus_req_ready(a_req_ready),
    .bus_resp_rdata(a_rdata), .bus_resp_ren(a_ren), .bus_resp_size(a_size),
    .bus_resp_dstid(a_dstid), .bus_resp_valid(a_valid), .bus_resp_ready(resp_ready)
  );

  kl_ram_responder #(.DEPTH_LOG2(4), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .bus_req_addr(req_addr), .bus_req_wen(req_wen), .bus_req_wdata(req_wdata),
    .bus_req_wmask(req_wmask), .bus_req_size(req_size), .bus_req_srcid(req_srcid),
    .bus_req_valid(req_valid & sel), .bus_req_ready(b_req_ready),
    .bus_resp_rdata(b_rdata), .bus_resp_ren(b_ren), .bus_resp_size(b_size),
    .bus_resp_dstid(b_dstid), .bus_resp_valid(b_valid), .bus_resp_ready(resp_ready)
  );

  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_ren       = sel ? b_ren       : a_ren;
  assign o_valid     = sel ? b_valid     : a_valid;
  assign o_rdata     = sel ? b_rdata     : a_rdata;
  assign o_size      = sel ? b_size      : a_size;
  assign o_dstid     = sel ? b_dstid     : a_dstid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] addr, input logic wen, input logic [63:0] wd,
                      input logic [7:0] m, input logic [2:0] sz, input logic [4:0] id);
    int n;
    n = 0;
    req_addr = addr; req_wen = wen; req_wdata = wd; req_wmask = m;
    req_size = sz; req_srcid = id; req_valid = 1'b1;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 64'(o_req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat);
    int n;
    n = 0;
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic recv(input string tag, input logic [63:0] rd, input logic ren,
                      input logic [2:0] sz, input logic [4:0] id, input int stall);
    check({tag, ".valid"}, 64'(o_valid), 64'd1);
    check({tag, ".rdata"}, o_rdata, rd);
    check({tag, ".ren"},   64'(o_ren), 64'(ren));
    check({tag, ".size"},  64'(o_size), 64'(sz));
    check({tag, ".dstid"}, 64'(o_dstid), 64'(id));
    if (stall > 0) begin
      resp_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, 64'(o_valid), 64'd1);
        check({tag, ".hold_rdata"}, o_rdata, rd);
        check({tag, ".hold_dstid"}, 64'(o_dstid), 64'(id));
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".resp_valid"}, 64'(o_valid), 64'd0);
    check({tag, ".req_ready"},  64'(o_req_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_b [8];
    exp_b = '{64'hAAAA, 64'd1, 64'd2, 64'd3, 64'd4, 64'hB0, 64'hB1, 64'hB2};
    rst = 1'b0; sel = 1'b0; resp_ready = 1'b1; req_valid = 1'b0;
    req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wmask = '0; req_size = '0; req_srcid = '0;

    repeat (3) @(negedge clk);
    check("rst.a_req_ready", 64'(a_req_ready), 64'd0);
    check("rst.b_req_ready", 64'(b_req_ready), 64'd0);
    check("rst.a_valid", 64'(a_valid), 64'd0);
    check("rst.a_rdata", a_rdata, 64'd0);
    check("rst.a_dstid", 64'(a_dstid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst.req_ready", 64'(a_req_ready), 64'd1);

    // Single write then read back
    send(32'h80, 1'b1, 64'h1122334455667788, 8'hFF, 3'd0, 5'd3);
    wait_resp(2);
    recv("wr_ack", 64'd0, 1'b0, 3'd0, 5'd3, 0);
    check_idle("after_ack");
    send(32'h80, 1'b0, 64'd0, 8'h00, 3'd0, 5'd3);
    wait_resp(2);
    recv("rd80", 64'h1122334455667788, 1'b1, 3'd0, 5'd3, 0);
    check_idle("after_rd");

    // Byte mask
    send(32'h100, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 3'd0, 5'd1);
    wait_resp(2); recv("mask_ack0", 64'd0, 1'b0, 3'd0, 5'd1, 0);
    send(32'h100, 1'b1, 64'd0, 8'h0F, 3'd0, 5'd1);
    wait_resp(2); recv("mask_ack1", 64'd0, 1'b0, 3'd0, 5'd1, 0);
    send(32'h100, 1'b0, 64'd0, 8'h00, 3'd0, 5'd1);
    wait_resp(2); recv("mask_rd", 64'hFFFFFFFF00000000, 1'b1, 3'd0, 5'd1, 0);

    // Preload neighbours, then 4-beat write of 1..4 at 0x200
    send(32'h1F8, 1'b1, 64'hAAAA, 8'hFF, 3'd0, 5'd2);
    wait_resp(2); recv("pre_ack", 64'd0, 1'b0, 3'd0, 5'd2, 0);
    for (int i = 0; i < 4; i++) send(32'h220, 1'b1, 64'hB0 + 64'(i), 8'hFF, 3'd2, 5'd2);
    wait_resp(2); recv("pre_burst_ack", 64'd0, 1'b0, 3'd2, 5'd2, 0);
    for (int i = 0; i < 4; i++) send(32'h200, 1'b1, 64'(i + 1), 8'hFF, 3'd2, 5'd4);
    wait_resp(2); recv("burst_ack", 64'd0, 1'b0, 3'd2, 5'd4, 0);

    // 8-beat read, then again with beat 2 held off for 5 cycles
    send(32'h1F8, 1'b0, 64'd0, 8'h00, 3'd3, 5'd5);
    wait_resp(2);
    for (int i = 0; i < 8; i++) recv($sformatf("burst_rd%0d", i), exp_b[i], 1'b1, 3'd3, 5'd5, 0);
    check_idle("after_burst");
    send(32'h1F8, 1'b0, 64'd0, 8'h00, 3'd3, 5'd6);
    wait_resp(2);
    for (int i = 0; i < 8; i++)
      recv($sformatf("bp_rd%0d", i), exp_b[i], 1'b1, 3'd3, 5'd6, (i == 2) ? 5 : 0);
    check_idle("after_bp");

    // Wrap and alias on the 16-word, latency-1 instance
    sel = 1'b1;
    @(negedge clk);
    send(32'h78, 1'b1, 64'h55, 8'hFF, 3'd1, 5'd7);
    send(32'h0,  1'b1, 64'h66, 8'hFF, 3'd1, 5'd7);
    wait_resp(1); recv("wrap_ack", 64'd0, 1'b0, 3'd1, 5'd7, 0);
    send(32'h80, 1'b0, 64'd0, 8'h00, 3'd0, 5'd7);
    wait_resp(1); recv("alias_rd", 64'h66, 1'b1, 3'd0, 5'd7, 0);
    send(32'h78, 1'b0, 64'd0, 8'h00, 3'd1, 5'd7);
    wait_resp(1);
    recv("wrap_rd0", 64'h55, 1'b1, 3'd1, 5'd7, 0);
    recv("wrap_rd1", 64'h66, 1'b1, 3'd1, 5'd7, 0);
    check_idle("after_wrap");
    sel = 1'b0;
    @(negedge clk);

    // Reset in the middle of a read burst
    send(32'h1F8, 1'b0, 64'd0, 8'h00, 3'd3, 5'd9);
    wait_resp(2);
    recv("mid_rd0", 64'hAAAA, 1'b1, 3'd3, 5'd9, 0);
    check("mid_rd1.valid", 64'(o_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst.valid", 64'(a_valid), 64'd0);
    check("mid_rst.rdata", a_rdata, 64'd0);
    check("mid_rst.dstid", 64'(a_dstid), 64'd0);
    check("mid_rst.req_ready", 64'(a_req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_mid_rst");
    send(32'h80, 1'b0, 64'd0, 8'h00, 3'd0, 5'd10);
    wait_resp(2); recv("post_rst_rd", 64'h1122334455667788, 1'b1, 3'd0, 5'd10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
